// File: rtl/sid_seq_pkg.sv
// sid_seq_pkg: shared FSM states and command-word field positions
// for the SID write sequencer and its wait timer.
package sid_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITE,
    S_WAIT
  } state_t;

  localparam int CMD_TYPE_BIT = 15;
  localparam int ADDR_MSB     = 12;
  localparam int ADDR_LSB     = 8;
  localparam int DATA_MSB     = 7;
  localparam int WAIT_MSB     = 14;
  localparam int WAIT_W       = WAIT_MSB + 1;
  localparam int SID_ADDR_W   = 5;

endpackage

// File: rtl/sid_wait_timer.sv
// sid_wait_timer: 15-bit load/decrement counter, saturates at 0.
// Ports: clk, reset_n, load, load_val, dec in; done (count==1) out.
module sid_wait_timer
  import sid_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              done
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == WAIT_W'(1));

endmodule

// File: rtl/sid_write_sequencer.sv
// sid_write_sequencer: pops FIFO commands, issues SID writes/waits on phi2.
// Ports: clk, reset_n, enable, phi2_tick, fifo_* in/out, sid_*, busy, waiting.
module sid_write_sequencer
  import sid_seq_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int FILL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  phi2_tick,
  input  logic [FILL_BITS-1:0]  fifo_fill,
  output logic                  fifo_rd_en,
  input  logic [BITS-1:0]       fifo_rd_data,
  output logic                  sid_we,
  output logic [SID_ADDR_W-1:0] sid_addr,
  output logic [7:0]            sid_data,
  output logic                  busy,
  output logic                  waiting
);

  state_t            state;
  logic              is_wait;
  logic [WAIT_W-1:0] wcount;
  logic              t_load;
  logic              t_dec;
  logic              t_done;

  assign is_wait = fifo_rd_data[CMD_TYPE_BIT];
  assign wcount  = fifo_rd_data[WAIT_MSB:0];
  assign t_load  = (state == S_DECODE) && is_wait;
  assign t_dec   = (state == S_WAIT) && phi2_tick;

  // Strobe must coincide with the phi2 tick itself.
  assign sid_we = (state == S_WRITE) && phi2_tick;

  sid_wait_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (wcount),
    .dec      (t_dec),
    .done     (t_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      waiting    <= 1'b0;
      sid_addr   <= '0;
      sid_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable && fifo_fill != '0) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          state      <= S_DECODE;
          fifo_rd_en <= 1'b0;
        end
        S_DECODE: begin
          if (!is_wait) begin
            state    <= S_WRITE;
            sid_addr <= fifo_rd_data[ADDR_MSB:ADDR_LSB];
            sid_data <= fifo_rd_data[DATA_MSB:0];
          end else if (wcount != '0) begin
            state   <= S_WAIT;
            waiting <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (phi2_tick) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (phi2_tick && t_done) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            waiting <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          fifo_rd_en <= 1'b0;
          busy       <= 1'b0;
          waiting    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_write_sequencer.sv
// tb_sid_write_sequencer: directed vectors against a FIFO/phi2 model.
// Drives on negedge, samples 2-3 ns after it.
module tb_sid_write_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        phi2_tick = 1'b0;
  logic [7:0]  fifo_fill = '0;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = '0;
  logic        sid_we;
  logic [4:0]  sid_addr;
  logic [7:0]  sid_data;
  logic        busy;
  logic        waiting;

  always #5 clk = ~clk;

  sid_write_sequencer #(.BITS(16), .FILL_BITS(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .phi2_tick    (phi2_tick),
    .fifo_fill    (fifo_fill),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .sid_we       (sid_we),
    .sid_addr     (sid_addr),
    .sid_data     (sid_data),
    .busy         (busy),
    .waiting      (waiting)
  );

  logic [15:0] q[$];
  int          we_tick[$];
  int cyc = 0, tick_no = 0, pops = 0, wes = 0;
  int wait_ticks = 0, busy_cyc = 0, underrun = 0, we_off = 0;
  int last_pop_cyc = 0, last_gap = 0, min_gap = 1000;
  int last_wait_tick = 0;
  logic [4:0] we_addr = '0;
  logic [7:0] we_data = '0;
  bit tick_en = 1'b1;
  int period = 8;

  int n_vec = 0, n_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      if (q.size() > 0) fifo_rd_data = q.pop_front();
      else begin
        underrun++;
        fifo_rd_data = '0;
      end
    end
    fifo_fill = 8'(q.size());
    phi2_tick = tick_en && (cyc % period == 0);
    #2;
    if (fifo_rd_en) begin
      pops++;
      if (last_pop_cyc > 0) begin
        last_gap = cyc - last_pop_cyc;
        if (last_gap < min_gap) min_gap = last_gap;
      end
      last_pop_cyc = cyc;
    end
    if (busy) busy_cyc++;
    if (phi2_tick) tick_no++;
    if (phi2_tick && waiting) begin
      wait_ticks++;
      last_wait_tick = tick_no;
    end
    if (sid_we) begin
      wes++;
      we_addr = sid_addr;
      we_data = sid_data;
      we_tick.push_back(tick_no);
      if (!phi2_tick) we_off++;
    end
  end

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  int b_p, b_w, b_t, b_b;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    step(3);
    expect_eq("rst_rd_en", fifo_rd_en, 0);
    expect_eq("rst_we",    sid_we,     0);
    expect_eq("rst_addr",  sid_addr,   0);
    expect_eq("rst_data",  sid_data,   0);
    expect_eq("rst_busy",  busy,       0);
    expect_eq("rst_wait",  waiting,    0);
    reset_n = 1'b1;
    step(2);

    // single write
    enable = 1'b1;
    q.push_back(16'h0418);
    step(40);
    expect_eq("w1_pops", pops, 1);
    expect_eq("w1_wes",  wes,  1);
    expect_eq("w1_addr", we_addr, 5'h04);
    expect_eq("w1_data", we_data, 8'h18);
    expect_eq("w1_busy", busy, 0);

    // wait 3 then write
    b_p = pops; b_w = wes; b_t = wait_ticks;
    q.push_back(16'h8003);
    q.push_back(16'h0012);
    step(80);
    expect_eq("w3_ticks", wait_ticks - b_t, 3);
    expect_eq("w3_wes",   wes - b_w, 1);
    expect_eq("w3_pops",  pops - b_p, 2);
    expect_eq("w3_addr",  we_addr, 5'h00);
    expect_eq("w3_data",  we_data, 8'h12);
    expect_eq("w3_next",  we_tick[$], last_wait_tick + 1);

    // zero-count wait
    b_p = pops; b_w = wes; b_t = wait_ticks;
    q.push_back(16'h8000);
    q.push_back(16'h0055);
    step(40);
    expect_eq("w0_pops", pops - b_p, 2);
    expect_eq("w0_gap",  last_gap, 3);
    expect_eq("w0_tick", wait_ticks - b_t, 0);
    expect_eq("w0_wes",  wes - b_w, 1);
    expect_eq("w0_data", we_data, 8'h55);

    // back-to-back writes
    b_w = wes;
    q.push_back(16'h0101);
    q.push_back(16'h0202);
    q.push_back(16'h0303);
    step(60);
    expect_eq("b2b_wes",  wes - b_w, 3);
    expect_eq("b2b_span", we_tick[$] - we_tick[$-2], 2);
    expect_eq("b2b_addr", we_addr, 5'h03);
    expect_eq("b2b_data", we_data, 8'h03);

    // empty fifo
    b_p = pops; b_b = busy_cyc;
    step(100);
    expect_eq("emp_pops", pops - b_p, 0);
    expect_eq("emp_busy", busy_cyc - b_b, 0);

    // enable drop during wait
    b_p = pops; b_w = wes; b_t = wait_ticks;
    q.push_back(16'h8005);
    for (int i = 0; i < 50; i++) begin
      if (waiting) break;
      step(1);
    end
    expect_eq("en_wait_in", waiting, 1);
    enable = 1'b0;
    q.push_back(16'h0011);
    q.push_back(16'h0022);
    step(70);
    expect_eq("en_ticks", wait_ticks - b_t, 5);
    expect_eq("en_pops",  pops - b_p, 1);
    expect_eq("en_wes",   wes - b_w, 0);
    expect_eq("en_busy",  busy, 0);
    enable = 1'b1;
    step(50);
    expect_eq("en_wes2",  wes - b_w, 2);
    expect_eq("en_data",  we_data, 8'h22);

    // reset mid-write
    tick_en = 1'b0;
    b_w = wes;
    q.push_back(16'h0133);
    step(6);
    expect_eq("mr_busy", busy, 1);
    expect_eq("mr_addr", sid_addr, 5'h01);
    expect_eq("mr_data", sid_data, 8'h33);
    reset_n = 1'b0;
    #1;
    expect_eq("mr_r_busy", busy, 0);
    expect_eq("mr_r_wait", waiting, 0);
    expect_eq("mr_r_rden", fifo_rd_en, 0);
    expect_eq("mr_r_we",   sid_we, 0);
    expect_eq("mr_r_addr", sid_addr, 0);
    expect_eq("mr_r_data", sid_data, 0);
    tick_en = 1'b1;
    step(2);
    reset_n = 1'b1;
    b_p = pops;
    step(30);
    expect_eq("mr_wes",  wes - b_w, 0);
    expect_eq("mr_pops", pops - b_p, 0);

    expect_eq("underrun", underrun, 0);
    expect_eq("we_off",   we_off, 0);
    expect_eq("min_gap3", min_gap >= 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
